// File: rtl/neuro_cfg_loader.sv
// Transmit end of the neuron-array configuration shift chain: serialises config bytes
// MSB-first onto the chain with one conf_en per bit and collects the chain tail as readback bytes.
module neuro_cfg_loader #(
  parameter int unsigned N_NEURONS       = 25,
  parameter int unsigned BITS_PER_NEURON = 17,
  parameter int unsigned CLK_DIV         = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cfg_data,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic       chain_tail,
  output logic       bs_out,
  output logic       conf_en,
  output logic [7:0] rb_data,
  output logic       rb_valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned TOTAL     = N_NEURONS * BITS_PER_NEURON;
  localparam int unsigned NBYTES    = (TOTAL + 7) / 8;
  localparam int unsigned LAST_BITS = ((TOTAL % 8) == 0) ? 8 : (TOTAL % 8);
  localparam logic [15:0] TOTAL_W   = 16'(TOTAL);
  localparam logic [15:0] NBYTES_W  = 16'(NBYTES);
  localparam logic [3:0]  LAST_W    = 4'(LAST_BITS);
  localparam logic [7:0]  DIV_MAX   = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  sh_q, sh_d;
  logic [3:0]  sh_cnt_q, sh_cnt_d;
  logic [7:0]  div_q, div_d;
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] ld_q, ld_d;
  logic [7:0]  rb_q, rb_d;
  logic [2:0]  rb_cnt_q, rb_cnt_d;
  logic [7:0]  rb_data_q, rb_data_d;
  logic        rb_valid_q, rb_valid_d;
  logic        conf_en_q, conf_en_d;
  logic        bs_out_q, bs_out_d;
  logic        cfg_ready_q, cfg_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        last_bit_s;
  logic        run_s;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      sh_q        <= 8'd0;
      sh_cnt_q    <= 4'd0;
      div_q       <= 8'd0;
      bit_cnt_q   <= 16'd0;
      acc_q       <= 16'd0;
      ld_q        <= 16'd0;
      rb_q        <= 8'd0;
      rb_cnt_q    <= 3'd0;
      rb_data_q   <= 8'd0;
      rb_valid_q  <= 1'b0;
      conf_en_q   <= 1'b0;
      bs_out_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      sh_cnt_q    <= sh_cnt_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      acc_q       <= acc_d;
      ld_q        <= ld_d;
      rb_q        <= rb_d;
      rb_cnt_q    <= rb_cnt_d;
      rb_data_q   <= rb_data_d;
      rb_valid_q  <= rb_valid_d;
      conf_en_q   <= conf_en_d;
      bs_out_q    <= bs_out_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic; outside RUN (and on abort) every work register falls back to empty
  always_comb begin
    state_d     = ST_IDLE;
    hold_d      = hold_q;
    hold_full_d = 1'b0;
    sh_d        = 8'd0;
    sh_cnt_d    = 4'd0;
    div_d       = 8'd0;
    bit_cnt_d   = 16'd0;
    acc_d       = 16'd0;
    ld_d        = 16'd0;
    rb_d        = 8'd0;
    rb_cnt_d    = 3'd0;
    rb_data_d   = rb_data_q;
    rb_valid_d  = 1'b0;
    last_bit_s  = conf_en_q && (bit_cnt_q == (TOTAL_W - 16'd1));

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          state_d     = ST_RUN;
          hold_full_d = hold_full_q;
          sh_d        = sh_q;
          sh_cnt_d    = sh_cnt_q;
          bit_cnt_d   = bit_cnt_q;
          acc_d       = acc_q;
          ld_d        = ld_q;
          rb_d        = rb_q;
          rb_cnt_d    = rb_cnt_q;

          if (cfg_valid && cfg_ready_q) begin
            hold_d      = cfg_data;
            hold_full_d = 1'b1;
            acc_d       = acc_q + 16'd1;
          end else begin
            hold_d = hold_q;
          end

          // conf_en_q marks the strobe: the chain takes bs_out now and presents its tail bit
          if (conf_en_q) begin
            sh_d     = {sh_q[6:0], 1'b0};
            sh_cnt_d = sh_cnt_q - 4'd1;
            if (bit_cnt_q != TOTAL_W) begin
              bit_cnt_d = bit_cnt_q + 16'd1;
            end else begin
              bit_cnt_d = bit_cnt_q;
            end
            rb_d[3'd7 - rb_cnt_q] = chain_tail;
            if ((rb_cnt_q == 3'd7) || last_bit_s) begin
              rb_data_d  = rb_d;
              rb_valid_d = 1'b1;
              rb_d       = 8'd0;
              rb_cnt_d   = 3'd0;
            end else begin
              rb_cnt_d = rb_cnt_q + 3'd1;
            end
            if (last_bit_s) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            sh_cnt_d = sh_cnt_q;
          end

          // Refill in the same cycle the last bit leaves so CLK_DIV=1 streams without gaps
          if ((sh_cnt_d == 4'd0) && hold_full_q) begin
            sh_d        = hold_q;
            sh_cnt_d    = (ld_q == (NBYTES_W - 16'd1)) ? LAST_W : 4'd8;
            hold_full_d = 1'b0;
            ld_d        = ld_q + 16'd1;
          end else begin
            ld_d = ld_q;
          end

          if ((sh_cnt_q == 4'd0) || (div_q == DIV_MAX)) begin
            div_d = 8'd0;
          end else begin
            div_d = div_q + 8'd1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    run_s       = (state_d == ST_RUN);
    conf_en_d   = run_s && (sh_cnt_d != 4'd0) && (div_d == DIV_MAX);
    bs_out_d    = run_s && (sh_cnt_d != 4'd0) && sh_d[7];
    cfg_ready_d = run_s && !hold_full_d && (acc_d < NBYTES_W);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  assign cfg_ready = cfg_ready_q;
  assign bs_out    = bs_out_q;
  assign conf_en   = conf_en_q;
  assign rb_data   = rb_data_q;
  assign rb_valid  = rb_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
